// File: rtl/kgp_arb_pkg.sv
// Shared types and defaults for the KGP_RISC memory-port arbiter.
// Optional feature macro: KGP_ARB_RR_EN (round-robin tie resolution).
`timescale 1ns/1ps
package kgp_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned MEM_LAT_DEF = 2;
    localparam int unsigned CNT_W_DEF   = 4;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Owner encoding doubles as the address-mux select (1 passes requester A)
    typedef enum logic {
        OWN_B = 1'b0,
        OWN_A = 1'b1
    } owner_t;

    // Tie resolution: round-robin favours the requester that did not win last,
    // fixed priority always favours the load/store side
    function automatic owner_t tie_winner(input owner_t last_owner, input logic rr_en);
        owner_t w;
        w = OWN_B;
        if (rr_en) begin
            w = (last_owner == OWN_A) ? OWN_B : OWN_A;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux2x1_32bit.sv
// 2:1 word select; sel = 1 passes a, sel = 0 passes b.
`timescale 1ns/1ps
module mux2x1_32bit #(
    parameter int unsigned W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y_c
);

    // Pure combinational steering
    assign y_c = sel ? a : b;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared KGP_RISC memory port.
// A = instruction fetch, B = load/store. Holds the port for MEM_LAT cycles,
// then pulses done with captured read data and inserts one bubble cycle.
// Optional feature macro: KGP_ARB_RR_EN (round-robin ties; default fixed B priority).
`timescale 1ns/1ps
module mem_port_arbiter
    import kgp_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] wdata_b,
    input  logic              we_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic [ADDR_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              busy
);

`ifdef KGP_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t        state_q;
    owner_t            owner_q;
    owner_t            last_owner_q;
    logic [CNT_W-1:0]  cnt_q;
    owner_t            winner_c;
    logic              sel_c;
    logic [ADDR_W-1:0] addr_sel_c;

    // Pick this cycle's winner from the live requests
    always_comb begin
        winner_c = OWN_B;
        if (req_a && req_b) begin
            winner_c = tie_winner(last_owner_q, RR_EN);
        end else if (req_a) begin
            winner_c = OWN_A;
        end
    end

    // Address select follows the winner while idle, the owner otherwise
    assign sel_c = (state_q == IDLE) ? (winner_c == OWN_A) : (owner_q == OWN_A);

    mux2x1_32bit #(
        .W (ADDR_W)
    ) u_addr_mux (
        .sel (sel_c),
        .a   (addr_a),
        .b   (addr_b),
        .y_c (addr_sel_c)
    );

    // Sequencer: accept, hold the port for MEM_LAT cycles, complete, bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_B;
            last_owner_q <= OWN_B;
            cnt_q        <= '0;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            done_a       <= 1'b0;
            done_b       <= 1'b0;
            rdata        <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        state_q      <= BUSY;
                        owner_q      <= winner_c;
                        last_owner_q <= winner_c;
                        mem_addr     <= addr_sel_c;
                        mem_en       <= 1'b1;
                        busy         <= 1'b1;
                        cnt_q        <= CNT_W'(MEM_LAT - 1);
                        if (winner_c == OWN_B) begin
                            mem_we    <= we_b;
                            mem_wdata <= wdata_b;
                            gnt_b     <= 1'b1;
                        end else begin
                            mem_we <= 1'b0;
                            gnt_a  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        // Stores leave the last read data untouched
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        done_a  <= (owner_q == OWN_A);
                        done_b  <= (owner_q == OWN_B);
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes predicted transactions,
// a negedge monitor pops and compares on every grant/completion.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, we_b;
    logic [31:0] addr_a, addr_b, wdata_b;
    logic        gnt_a, gnt_b, done_a, done_b, mem_en, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        req1_a;
    logic [31:0] addr1_a;
    logic        gnt1_a, gnt1_b, done1_a, done1_b, mem1_en, mem1_we, busy1;
    logic [31:0] rdata1, mem1_addr, mem1_wdata, mem1_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .addr_a(addr_a),
        .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .req_a(req1_a), .addr_a(addr1_a),
        .req_b(1'b0), .addr_b(32'h0), .wdata_b(32'h0), .we_b(1'b0),
        .gnt_a(gnt1_a), .gnt_b(gnt1_b), .done_a(done1_a), .done_b(done1_b),
        .rdata(rdata1), .mem_en(mem1_en), .mem_we(mem1_we),
        .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata),
        .busy(busy1)
    );

    // Memory contents as seen by a read
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Port read data: valid only for reads, junk otherwise
    always_comb begin
        if (mem_en && !mem_we) mem_rdata = rd_fn(mem_addr);
        else                   mem_rdata = ~rd_fn(mem_addr) ^ 32'h0101_0101;
        if (mem1_en && !mem1_we) mem1_rdata = rd_fn(mem1_addr);
        else                     mem1_rdata = ~rd_fn(mem1_addr) ^ 32'h0101_0101;
    end

    typedef struct {
        bit          own_a;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   sb_on = 0;
    bit   last_own_a = 0;
    logic [31:0] rdata_m = 32'h0;

    exp_t cur;
    bit   active = 0;
    bit   resp_next = 0;
    int   en_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'({gnt_a, gnt_b}), 32'h0);
        chk({tag, "_done"},  32'({done_a, done_b}), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_en_we"}, 32'({mem_en, mem_we}), 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_maddr"}, mem_addr, 32'h0);
        chk({tag, "_mwdat"}, mem_wdata, 32'h0);
    endtask

    // Reference arbitration: lone requester wins; ties per build mode
    function automatic bit model_win_a(input bit ra, input bit rb);
        if (ra && !rb) return 1'b1;
        if (!ra && rb) return 1'b0;
`ifdef KGP_ARB_RR_EN
        return !last_own_a;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_exp(input bit win_a, input logic [31:0] aa, input logic [31:0] ab,
                            input logic [31:0] wd, input bit we);
        exp_t e;
        e.own_a = win_a;
        e.addr  = win_a ? aa : ab;
        e.we    = win_a ? 1'b0 : we;
        e.wdata = wd;
        if (!e.we) rdata_m = rd_fn(e.addr);
        e.rdata = rdata_m;
        last_own_a = win_a;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk_evt("wait_idle_timeout");
    endtask

    // One arbitration round; requests drop right after the grant
    task automatic issue(input bit ra, input bit rb, input logic [31:0] aa, input logic [31:0] ab,
                         input logic [31:0] wd, input bit we, input bit pulse_a);
        bit ok;
        wait_idle();
        push_exp(model_win_a(ra, rb), aa, ab, wd, we);
        addr_a = aa; addr_b = ab; wdata_b = wd; we_b = we;
        req_a = ra; req_b = rb;
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin ok = 1; break; end
        end
        req_a = 0; req_b = 0;
        if (!ok) chk_evt("gnt_timeout");
        if (pulse_a && ok && gnt_b) begin
            addr_a = 32'h0000_0BAD; req_a = 1;
            @(negedge clk);
            req_a = 0;
        end
    endtask

    // Both requests held high for n grants
    task automatic contend(input int n);
        int got, cyc, last_cyc;
        logic [31:0] aa, ab, wd;
        bit we;
        wait_idle();
        aa = $urandom & 32'hFFFF_FFFC; ab = $urandom & 32'hFFFF_FFFC;
        wd = $urandom; we = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) push_exp(model_win_a(1, 1), aa, ab, wd, we);
        addr_a = aa; addr_b = ab; wdata_b = wd; we_b = we;
        req_a = 1; req_b = 1;
        got = 0; cyc = 0; last_cyc = 0;
        while (got < n && cyc < n * (LAT + 2) + 8) begin
            @(negedge clk);
            cyc++;
            if (gnt_a || gnt_b) begin
                if (got > 0) chk("gnt_spacing", 32'(cyc - last_cyc), 32'(LAT + 2));
                last_cyc = cyc;
                got++;
            end
        end
        req_a = 0; req_b = 0;
        if (got < n) chk_evt("contend_timeout");
    endtask

    // Monitor: compares grants, port contents and completions against the queue
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (resp_next) begin
                    chk("busy_after_resp", 32'(busy), 32'h0);
                    resp_next = 0;
                end
                if (gnt_a || gnt_b) begin
                    if (active) chk_evt("gnt_while_active");
                    if (q.size() == 0) begin
                        chk_evt("unexpected_gnt");
                    end else begin
                        cur = q.pop_front();
                        active = 1;
                        en_cnt = 0;
                        chk("gnt_owner", 32'({gnt_a, gnt_b}), cur.own_a ? 32'h2 : 32'h1);
                        chk("mem_addr", mem_addr, cur.addr);
                        chk("mem_we", 32'(mem_we), 32'(cur.we));
                        chk("busy_on_gnt", 32'(busy), 32'h1);
                        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end
                if (mem_en) en_cnt++;
                if (done_a || done_b) begin
                    if (!active) begin
                        chk_evt("unexpected_done");
                    end else begin
                        chk("done_owner", 32'({done_a, done_b}), cur.own_a ? 32'h2 : 32'h1);
                        chk("rdata", rdata, cur.rdata);
                        chk("mem_en_cycles", 32'(en_cnt), 32'(LAT));
                        active = 0;
                        resp_next = 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        rst = 0; req_a = 0; req_b = 0; we_b = 0;
        addr_a = 0; addr_b = 0; wdata_b = 0;
        req1_a = 0; addr1_a = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1;
        @(negedge clk);

        // Reset while the port is busy
        addr_a = 32'h0000_0080; req_a = 1;
        @(negedge clk);
        req_a = 0;
        chk("pre_rst_gnt", 32'(gnt_a), 32'h1);
        @(negedge clk);
        chk("pre_rst_en", 32'(mem_en), 32'h1);
        rst = 0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({done_a, done_b, gnt_a, gnt_b, busy}), 32'h0);
        end
        last_own_a = 0;
        rdata_m = 32'h0;
        sb_on = 1;

        // Directed fetch and store (with a withdrawn fetch pulse during the store)
        issue(1, 0, 32'h0000_0040, 32'h0, 32'h0, 0, 0);
        issue(0, 1, 32'h0, 32'h0000_0100, 32'h1234_5678, 1, 1);
        contend(4);

        // Randomised rounds
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(kind != 1, kind != 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                  $urandom, 1'($urandom_range(0, 1)), kind == 1 && $urandom_range(0, 1) == 1);
        end
        contend(3);

        // Drain
        for (int i = 0; i < 20 && (active || busy); i++) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        chk("monitor_idle", 32'(active), 32'h0);
        sb_on = 0;

        // MEM_LAT = 1 back-to-back fetches
        addr1_a = 32'h0000_0040; req1_a = 1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("lat1_gnt",  32'(gnt1_a),  32'(k % 3 == 0));
            chk("lat1_done", 32'(done1_a), 32'(k % 3 == 1));
            chk("lat1_en",   32'(mem1_en), 32'(k % 3 == 0));
            chk("lat1_busy", 32'(busy1),   32'(k % 3 != 2));
            chk("lat1_b",    32'({gnt1_b, done1_b}), 32'h0);
            if (k % 3 == 1) chk("lat1_rdata", rdata1, 32'hDEAD_BEEF);
        end
        req1_a = 0;
        chk("lat1_wdata", mem1_wdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
